nabp_processing_swappable: RTL and testbench

Line-processing front end of the NABP back-projector. Per iteration it maps a line of detector positions to filtered-RAM addresses (mapper accumulator) and fills a partitioned shift register from the filtered RAM. It then advances that register at a fractional rate (shifter accumulator) while enabling the PEs, which read one tap per partition. It sits between the swap controller, the filtered RAM and the PE array. Accumulator bases and inits come from the registered angle LUTs (mapper LUT, shifter LUT).

---
 rtl/nabp_processing_swappable.sv | 145 ++++++++++++++
 tb/tb_nabp_processing_swappable.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/nabp_processing_swappable.sv
// NABP line-processing front end: maps detector positions to filtered-RAM reads,
// fills a partitioned shift register, then advances it at a fractional rate for the PEs.
module nabp_processing_swappable #(
    parameter int kFilteredDataLength = 12,
    parameter int kNoOfPartitions     = 4,
    parameter int kPartitionSize      = 8,
    parameter int kLineLength         = 32,
    parameter int kProjLineSize       = 256,
    parameter int kSLength            = 9,
    parameter int MP_W                = 18,
    parameter int MP_FRAC             = 8,
    parameter int SH_FRAC             = 8
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic [SH_FRAC:0]                              sw_sh_accu_base,
    input  logic signed [MP_W-1:0]                        sw_mp_accu_init,
    input  logic signed [MP_W-1:0]                        sw_mp_accu_base,
    input  logic                                          sw_swap_ack,
    input  logic                                          sw_next_itr_ack,
    input  logic [kFilteredDataLength-1:0]                fr_val,
    output logic                                          sw_swap,
    output logic                                          sw_next_itr,
    output logic                                          sw_pe_en,
    output logic [kSLength-1:0]                           fr_s_val,
    output logic [kFilteredDataLength*kNoOfPartitions-1:0] pe_taps
);
    localparam int N     = kNoOfPartitions * kPartitionSize;
    localparam int CMAX  = (N > kLineLength) ? N : kLineLength;
    localparam int CW    = $clog2(CMAX + 1);
    localparam int S_W   = MP_W - MP_FRAC;

    typedef enum logic [1:0] {REQ, FILL, SWAP, PROC} state_t;

    state_t                        state;
    logic [CW-1:0]                 cnt;
    logic signed [MP_W-1:0]        mp_accu;
    logic signed [MP_W-1:0]        mp_base;
    logic [SH_FRAC:0]              sh_base;
    logic [SH_FRAC-1:0]            sh_frac;
    logic [SH_FRAC+1:0]            sh_sum;
    logic                          carry;
    logic                          issue;
    logic                          pend;
    logic signed [S_W-1:0]         s_raw;
    logic [kSLength-1:0]           s_clamp;
    logic [kFilteredDataLength-1:0] sreg [N];

    // Integer part of the mapper accumulator is a floor, since the slice drops fraction bits.
    assign s_raw  = mp_accu[MP_W-1:MP_FRAC];
    assign sh_sum = {2'b00, sh_frac} + {1'b0, sh_base};
    assign carry  = |sh_sum[SH_FRAC+1:SH_FRAC];
    assign issue  = ((state == FILL) && (cnt < CW'(N))) || ((state == PROC) && carry);

    always_comb begin
        s_clamp = '0;
        if (s_raw[S_W-1])
            s_clamp = '0;
        else if (s_raw > $signed(S_W'(kProjLineSize - 1)))
            s_clamp = kSLength'(kProjLineSize - 1);
        else
            s_clamp = s_raw[kSLength-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= REQ;
            cnt         <= '0;
            mp_accu     <= '0;
            mp_base     <= '0;
            sh_base     <= '0;
            sh_frac     <= '0;
            sw_swap     <= 1'b0;
            sw_next_itr <= 1'b0;
            sw_pe_en    <= 1'b0;
            fr_s_val    <= '0;
        end else begin
            if (issue) begin
                fr_s_val <= s_clamp;
                mp_accu  <= mp_accu + mp_base;
            end
            case (state)
                REQ: begin
                    if (sw_next_itr && sw_next_itr_ack) begin
                        sw_next_itr <= 1'b0;
                        mp_accu     <= sw_mp_accu_init;
                        mp_base     <= sw_mp_accu_base;
                        sh_base     <= sw_sh_accu_base;
                        sh_frac     <= '0;
                        cnt         <= '0;
                        state       <= FILL;
                    end else begin
                        sw_next_itr <= 1'b1;
                    end
                end
                // Count runs one past the last read so the final shift lands before SWAP.
                FILL: begin
                    if (cnt == CW'(N)) begin
                        sw_swap <= 1'b1;
                        state   <= SWAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SWAP: begin
                    if (sw_swap_ack) begin
                        sw_swap  <= 1'b0;
                        sw_pe_en <= 1'b1;
                        cnt      <= '0;
                        state    <= PROC;
                    end
                end
                PROC: begin
                    sh_frac <= sh_sum[SH_FRAC-1:0];
                    if (cnt == CW'(kLineLength - 1)) begin
                        sw_pe_en <= 1'b0;
                        state    <= REQ;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

    // Shift lags its read by one cycle; this also drains the last PROC read during REQ.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend <= 1'b0;
            for (int i = 0; i < N; i++) sreg[i] <= '0;
        end else begin
            pend <= issue;
            if (pend) begin
                for (int i = 0; i < N - 1; i++) sreg[i] <= sreg[i+1];
                sreg[N-1] <= fr_val;
            end
        end
    end

    for (genvar p = 0; p < kNoOfPartitions; p++) begin : g_tap
        assign pe_taps[p*kFilteredDataLength +: kFilteredDataLength] = sreg[p*kPartitionSize];
    end

endmodule

// File: tb/tb_nabp_processing_swappable.sv
// Randomized bench for nabp_processing_swappable against a stream-level model of
// addresses (mapper arithmetic) and register contents (last N samples shifted in).
module tb_nabp_processing_swappable;
    localparam int W  = 12;
    localparam int NP = 4;
    localparam int PS = 8;
    localparam int N  = NP * PS;
    localparam int LL = 32;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [8:0]           sw_sh_accu_base = '0;
    logic signed [17:0]   sw_mp_accu_init = '0;
    logic signed [17:0]   sw_mp_accu_base = '0;
    logic                 sw_swap_ack = 1'b0;
    logic                 sw_next_itr_ack = 1'b0;
    logic [W-1:0]         fr_val;
    logic                 sw_swap;
    logic                 sw_next_itr;
    logic                 sw_pe_en;
    logic [8:0]           fr_s_val;
    logic [W*NP-1:0]      pe_taps;

    int ram [512];
    int strm [$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign fr_val = W'(ram[fr_s_val]);

    nabp_processing_swappable dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .sw_sh_accu_base (sw_sh_accu_base),
        .sw_mp_accu_init (sw_mp_accu_init),
        .sw_mp_accu_base (sw_mp_accu_base),
        .sw_swap_ack     (sw_swap_ack),
        .sw_next_itr_ack (sw_next_itr_ack),
        .fr_val          (fr_val),
        .sw_swap         (sw_swap),
        .sw_next_itr     (sw_next_itr),
        .sw_pe_en        (sw_pe_en),
        .fr_s_val        (fr_s_val),
        .pe_taps         (pe_taps)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clampi(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    // Register holds the last N samples of everything shifted in since reset.
    function automatic logic [W*NP-1:0] exp_taps(input int s);
        logic [W*NP-1:0] v = '0;
        for (int p = 0; p < NP; p++) begin
            int idx = s - N + p * PS;
            if (idx >= 0) v[p*W +: W] = W'(strm[idx]);
        end
        return v;
    endfunction

    task automatic run_iter(input int init, input int mb, input int sb,
                            input int dly, input int hold2, input int abort_j);
        int addr [$];
        int base, r_tot, t, r, sh;
        base  = strm.size();
        r_tot = LL * sb / 256;
        for (int k = 0; k < N + r_tot; k++) begin
            addr.push_back(clampi((init + k * mb) >>> 8));
            strm.push_back(ram[addr[k]]);
        end

        t = 0;
        while (sw_next_itr !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_eq("next_itr_req", sw_next_itr, 1);
        repeat ($urandom_range(2)) begin
            @(negedge clk);
            check_eq("next_itr_held", sw_next_itr, 1);
        end
        sw_mp_accu_init = 18'(init);
        sw_mp_accu_base = 18'(mb);
        sw_sh_accu_base = 9'(sb);
        sw_next_itr_ack = 1'b1;
        @(negedge clk);
        check_eq("next_itr_drop", sw_next_itr, 0);
        sw_next_itr_ack = hold2[0];

        for (int c = 1; c <= N; c++) begin
            @(negedge clk);
            sw_next_itr_ack = 1'b0;
            sw_swap_ack = (c == 3);
            check_eq("fill_addr", fr_s_val, addr[c-1]);
            check_eq("fill_no_swap", sw_swap, 0);
        end
        @(negedge clk);
        check_eq("swap_req", sw_swap, 1);
        check_eq("taps_fill", pe_taps, exp_taps(base + N));
        check_eq("pe_off_swap", sw_pe_en, 0);
        repeat (dly) begin
            @(negedge clk);
            check_eq("swap_held", sw_swap, 1);
            check_eq("taps_frozen", pe_taps, exp_taps(base + N));
            check_eq("pe_frozen", sw_pe_en, 0);
        end
        sw_swap_ack = 1'b1;

        for (int j = 1; j <= LL; j++) begin
            @(negedge clk);
            sw_swap_ack = 1'b0;
            sw_next_itr_ack = (j == 5);
            r  = (j - 1) * sb / 256;
            sh = base + N + ((j >= 2) ? (j - 2) * sb / 256 : 0);
            check_eq("pe_en", sw_pe_en, 1);
            check_eq("swap_low", sw_swap, 0);
            check_eq("proc_taps", pe_taps, exp_taps(sh));
            check_eq("proc_addr", fr_s_val, addr[N-1+r]);
            if (j == abort_j) begin
                reset_n = 1'b0;
                #1;
                check_eq("rst_swap", sw_swap, 0);
                check_eq("rst_next_itr", sw_next_itr, 0);
                check_eq("rst_pe_en", sw_pe_en, 0);
                check_eq("rst_addr", fr_s_val, 0);
                check_eq("rst_taps", pe_taps, 0);
                strm.delete();
                sw_next_itr_ack = 1'b0;
                @(negedge clk);
                @(negedge clk);
                reset_n = 1'b1;
                @(negedge clk);
                check_eq("rst_next_itr_rise", sw_next_itr, 1);
                check_eq("rst_taps_after", pe_taps, 0);
                return;
            end
        end
        @(negedge clk);
        sw_next_itr_ack = 1'b0;
        check_eq("pe_off_drain", sw_pe_en, 0);
        check_eq("next_itr_drain", sw_next_itr, 0);
        @(negedge clk);
        check_eq("next_itr_again", sw_next_itr, 1);
        check_eq("taps_final", pe_taps, exp_taps(base + N + r_tot));
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = i;
        repeat (3) @(negedge clk);
        check_eq("reset_swap", sw_swap, 0);
        check_eq("reset_next_itr", sw_next_itr, 0);
        check_eq("reset_pe_en", sw_pe_en, 0);
        check_eq("reset_addr", fr_s_val, 0);
        check_eq("reset_taps", pe_taps, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("next_itr_after_reset", sw_next_itr, 1);

        run_iter(0, 256, 256, 1, 0, 0);
        run_iter(0, 362, 181, 0, 1, 0);
        run_iter(-1024, 256, 128, 2, 0, 0);
        run_iter(255 * 256, 256, 256, 0, 0, 0);
        run_iter(0, 256, 0, 5, 1, 0);

        for (int i = 0; i < 256; i++) ram[i] = int'($urandom_range(4095));
        for (int it = 0; it < 6; it++)
            run_iter(int'($urandom_range(70000)) - 4096, int'($urandom_range(900)) - 300,
                     int'($urandom_range(256)), int'($urandom_range(5)),
                     int'($urandom_range(1)), 0);

        run_iter(1000, 300, 200, 1, 0, 10);
        run_iter(int'($urandom_range(60000)), int'($urandom_range(500)),
                 int'($urandom_range(256)), 3, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
